// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion sequencer: integrates sub-pixel velocity once per frame,
// bounces off screen edges (or wraps when SPRITE_WRAP_EN is defined) and reverses on collision.
module sprite_motion_ctrl #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int OBJ_W     = 128,
    parameter int OBJ_H     = 64,
    parameter int FRAC_BITS = 4,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start_of_frame,
    input  logic        set_vel,
    input  logic [15:0] vel_x_in,
    input  logic [15:0] vel_y_in,
    input  logic        collision,
    output logic [31:0] topLeft_x,
    output logic [31:0] topLeft_y,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam logic signed [31:0] MAX_X   = 32'((SCREEN_W - OBJ_W) << FRAC_BITS);
    localparam logic signed [31:0] MAX_Y   = 32'((SCREEN_H - OBJ_H) << FRAC_BITS);
    localparam logic signed [31:0] INIT_FX = 32'(INIT_X << FRAC_BITS);
    localparam logic signed [31:0] INIT_FY = 32'(INIT_Y << FRAC_BITS);
`ifdef SPRITE_WRAP_EN
    localparam logic signed [31:0] STEP    = 32'(1 << FRAC_BITS);
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_MOVE, S_BOUND, S_COMMIT} state_t;

    typedef struct packed {
        logic signed [31:0] pos;
        logic signed [15:0] vel;
    } axis_t;

    // -(-32768) is not representable; saturate to +32767
    function automatic logic signed [15:0] sat_neg(input logic signed [15:0] v);
        return (v == 16'sh8000) ? 16'sh7FFF : -v;
    endfunction

    function automatic logic signed [15:0] abs_sat(input logic signed [15:0] v);
        return v[15] ? sat_neg(v) : v;
    endfunction

    function automatic logic signed [15:0] neg_abs(input logic signed [15:0] v);
        return v[15] ? v : -v;
    endfunction

    function automatic axis_t bound_axis(input logic signed [31:0] n,
                                         input logic signed [15:0] v,
                                         input logic signed [31:0] max);
        axis_t a;
        a.pos = n;
        a.vel = v;
`ifdef SPRITE_WRAP_EN
        if (n > max)
            a.pos = n - (max + STEP);
        else if (n < 0)
            a.pos = n + max + STEP;
`else
        if (n < 0) begin
            a.pos = '0;
            a.vel = abs_sat(v);
        end else if (n > max) begin
            a.pos = max;
            a.vel = neg_abs(v);
        end
`endif
        return a;
    endfunction

    state_t             r_state;
    logic signed [31:0] r_pos_x, r_pos_y;
    logic signed [31:0] r_nx, r_ny;
    logic signed [15:0] r_vel_x, r_vel_y;
    logic               r_col;
    logic               r_busy;
    logic [31:0]        r_top_x, r_top_y;
    logic [15:0]        r_frame_cnt;

    logic signed [15:0] w_mv_x, w_mv_y;
    logic signed [31:0] w_nx, w_ny;
    axis_t              w_bx, w_by;

    always_comb begin
        w_mv_x = r_col ? sat_neg(r_vel_x) : r_vel_x;
        w_mv_y = r_col ? sat_neg(r_vel_y) : r_vel_y;
        w_nx   = r_pos_x + {{16{w_mv_x[15]}}, w_mv_x};
        w_ny   = r_pos_y + {{16{w_mv_y[15]}}, w_mv_y};
        w_bx   = bound_axis(r_nx, r_vel_x, MAX_X);
        w_by   = bound_axis(r_ny, r_vel_y, MAX_Y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pos_x     <= INIT_FX;
            r_pos_y     <= INIT_FY;
            r_nx        <= '0;
            r_ny        <= '0;
            r_vel_x     <= '0;
            r_vel_y     <= '0;
            r_col       <= 1'b0;
            r_busy      <= 1'b0;
            r_top_x     <= 32'(INIT_X);
            r_top_y     <= 32'(INIT_Y);
            r_frame_cnt <= '0;
        end else begin
            // MOVE consumes the latch; a collision in that same cycle is kept for next frame
            if (r_state == S_MOVE)
                r_col <= collision;
            else if (collision)
                r_col <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (set_vel) begin
                        r_vel_x <= vel_x_in;
                        r_vel_y <= vel_y_in;
                    end
                    if (enable)
                        r_state <= S_WAIT_SOF;
                end
                S_WAIT_SOF: begin
                    if (set_vel) begin
                        r_vel_x <= vel_x_in;
                        r_vel_y <= vel_y_in;
                    end
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (start_of_frame) begin
                        r_state <= S_MOVE;
                        r_busy  <= 1'b1;
                    end
                end
                S_MOVE: begin
                    r_vel_x <= w_mv_x;
                    r_vel_y <= w_mv_y;
                    r_nx    <= w_nx;
                    r_ny    <= w_ny;
                    r_state <= S_BOUND;
                end
                S_BOUND: begin
                    r_pos_x <= w_bx.pos;
                    r_vel_x <= w_bx.vel;
                    r_pos_y <= w_by.pos;
                    r_vel_y <= w_by.vel;
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_top_x     <= r_pos_x >>> FRAC_BITS;
                    r_top_y     <= r_pos_y >>> FRAC_BITS;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_busy      <= 1'b0;
                    r_state     <= enable ? S_WAIT_SOF : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign topLeft_x = r_top_x;
    assign topLeft_y = r_top_y;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: directed scenarios then random stimulus
// against an arithmetic reference model of per-frame motion.
module tb_sprite_motion_ctrl;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int OBJ_W     = 128;
    localparam int OBJ_H     = 64;
    localparam int FRAC_BITS = 4;
    localparam int INIT_X    = 0;
    localparam int INIT_Y    = 0;
    localparam longint MAX_X = longint'(SCREEN_W - OBJ_W) * (longint'(1) << FRAC_BITS);
    localparam longint MAX_Y = longint'(SCREEN_H - OBJ_H) * (longint'(1) << FRAC_BITS);
    localparam longint ONE   = longint'(1) << FRAC_BITS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sof = 1'b0;
    logic        set_vel = 1'b0;
    logic [15:0] vx_in = '0;
    logic [15:0] vy_in = '0;
    logic        collision = 1'b0;
    logic [31:0] tlx, tly;
    logic        busy;
    logic [15:0] fcnt;

    sprite_motion_ctrl #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H),
        .FRAC_BITS(FRAC_BITS), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start_of_frame(sof),
        .set_vel(set_vel), .vel_x_in(vx_in), .vel_y_in(vy_in), .collision(collision),
        .topLeft_x(tlx), .topLeft_y(tly), .busy(busy), .frame_cnt(fcnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint x;
        longint y;
        longint cnt;
    } exp_t;
    exp_t q[$];

    // reference model: fixed-point position/velocity as plain integers
    longint m_px, m_py;
    longint m_vx, m_vy;
    longint m_cnt;
    bit     m_col;
    bit     m_waiting;
    int     m_busy;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic axis(inout longint p, inout longint v, input longint mx);
        longint n;
        n = p + v;
`ifdef SPRITE_WRAP_EN
        if (n > mx)     p = n - (mx + ONE);
        else if (n < 0) p = n + mx + ONE;
        else            p = n;
`else
        if (n < 0) begin
            p = 0;
            v = sat16(absl(v));
        end else if (n > mx) begin
            p = mx;
            v = -absl(v);
        end else begin
            p = n;
        end
`endif
    endtask

    task automatic model_reset();
        m_px = longint'(INIT_X) * ONE;
        m_py = longint'(INIT_Y) * ONE;
        m_vx = 0;
        m_vy = 0;
        m_cnt = 0;
        m_col = 0;
        m_waiting = 0;
        m_busy = 0;
        q.delete();
    endtask

    task automatic do_frame();
        exp_t e;
        if (m_col) begin
            m_vx = sat16(-m_vx);
            m_vy = sat16(-m_vy);
            m_col = 0;
        end
        axis(m_px, m_vx, MAX_X);
        axis(m_py, m_vy, MAX_Y);
        m_cnt = (m_cnt + 1) % 65536;
        e.x = m_px >>> FRAC_BITS;
        e.y = m_py >>> FRAC_BITS;
        e.cnt = m_cnt;
        q.push_back(e);
    endtask

    // Applies the inputs that the next rising edge will sample, and advances the model.
    task automatic cyc(input bit rst, input bit en, input bit s, input bit sv,
                       input logic [15:0] vx, input logic [15:0] vy, input bit col);
        bit accept;
        @(posedge clk);
        #1;
        reset = rst; enable = en; sof = s; set_vel = sv;
        vx_in = vx; vy_in = vy; collision = col;
        accept = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_waiting = en;
            end else begin
                if (sv) begin
                    m_vx = longint'($signed(vx));
                    m_vy = longint'($signed(vy));
                end
                if (!m_waiting) begin
                    if (en) m_waiting = 1;
                end else if (!en) begin
                    m_waiting = 0;
                end else if (s) begin
                    accept = 1;
                    m_busy = 3;
                    m_waiting = 0;
                end
            end
            if (col) m_col = 1;
            if (accept) do_frame();
        end
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(0, en, 0, 0, 16'h0, 16'h0, 0);
    endtask

    // monitor: every completed (non-reset) update pops one expected result
    bit rst_pend = 1'b1;
    bit prev_busy = 1'b0;
    int run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_pend) begin
            run = 0;
        end else if (busy) begin
            run++;
        end else if (prev_busy) begin
            chk("busy_len", run, 3);
            run = 0;
            if (q.size() == 0) begin
                chk("unexpected_update", 1, 0);
            end else begin
                e = q.pop_front();
                chk("top_x", longint'($signed(tlx)), e.x);
                chk("top_y", longint'($signed(tly)), e.y);
                chk("frame_cnt", longint'(fcnt), e.cnt);
            end
        end
        prev_busy = busy;
        rst_pend = reset;
    end

    initial begin
        bit en_r;
        model_reset();

        cyc(1, 0, 0, 0, 16'h0, 16'h0, 0);
        cyc(1, 0, 0, 0, 16'h0, 16'h0, 0);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 0);
        @(negedge clk);
        chk("rst_x", longint'(tlx), INIT_X);
        chk("rst_y", longint'(tly), INIT_Y);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_cnt", longint'(fcnt), 0);

        // basic move (2,1)
        cyc(0, 1, 0, 1, 16'd32, 16'd16, 0);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        idle(5, 1);

        // collision mid-frame reverses velocity next frame
        cyc(0, 1, 0, 1, 16'd16, 16'd16, 0);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        idle(4, 1);
        cyc(0, 1, 0, 0, 16'h0, 16'h0, 1);
        idle(2, 1);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        idle(5, 1);

        // collision in the MOVE cycle is deferred to the following frame
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        cyc(0, 1, 0, 0, 16'h0, 16'h0, 1);
        idle(5, 1);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        idle(5, 1);

        // set_vel and SOF together, then back-to-back SOF with a dropped set_vel
        cyc(0, 1, 1, 1, 16'd32, 16'd32, 0);
        cyc(0, 1, 1, 1, 16'd48, 16'd48, 0);
        idle(5, 1);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        idle(5, 1);

        // hit right edge and top edge, then bounce back past left edge
        cyc(0, 1, 1, 1, 16'h7FFF, 16'hFF9C, 0);
        idle(5, 1);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        idle(5, 1);

        // -32768 negated by collision saturates
        cyc(0, 1, 0, 1, 16'h8000, 16'h8000, 1);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        idle(5, 1);

        // enable drops mid-update, then SOFs while disabled are ignored
        cyc(0, 1, 0, 1, 16'd20, 16'd20, 0);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 0);
        idle(4, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
            idle(2, 0);
        end
        @(negedge clk);
        chk("hold_x", longint'($signed(tlx)), m_px >>> FRAC_BITS);
        chk("hold_y", longint'($signed(tly)), m_py >>> FRAC_BITS);
        chk("hold_cnt", longint'(fcnt), m_cnt);

        // reset during BOUND
        cyc(0, 1, 0, 0, 16'h0, 16'h0, 0);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        cyc(0, 1, 0, 0, 16'h0, 16'h0, 0);
        cyc(1, 1, 0, 0, 16'h0, 16'h0, 0);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        @(negedge clk);
        chk("midrst_x", longint'(tlx), INIT_X);
        chk("midrst_y", longint'(tly), INIT_Y);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_cnt", longint'(fcnt), 0);
        idle(4, 1);
        chk("idle_sof_ignored", longint'(fcnt), 0);
        cyc(0, 1, 1, 0, 16'h0, 16'h0, 0);
        idle(5, 1);

        // randomized traffic
        en_r = 1;
        for (int i = 0; i < 600; i++) begin
            bit rs, s, sv, col;
            logic [15:0] vx, vy;
            rs = ($urandom_range(0, 299) == 0);
            if (!m_waiting && m_busy == 0) en_r = 1;
            else if (m_busy > 0 && $urandom_range(0, 19) == 0) en_r = 0;
            s   = ($urandom_range(0, 3) == 0);
            sv  = ($urandom_range(0, 7) == 0);
            col = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                vx = 16'($urandom);
                vy = 16'($urandom);
            end else begin
                vx = 16'($signed(32'($urandom_range(0, 800))) - 400);
                vy = 16'($signed(32'($urandom_range(0, 800))) - 400);
            end
            cyc(rs, en_r, s, sv, vx, vy, col);
        end
        idle(8, 1);
        @(negedge clk);
        chk("queue_empty", longint'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
